// File: rtl/ifetch_prefetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch prefetch unit.
//   fetch_state_e : request FSM states (IDLE, WAIT, DISCARD)
//   fetch_entry_t : one queued fetch result {pcplus4, instr}
//   NOP_INSTR, DEFAULT_RESET_PC, word_align()
package ifetch_prefetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pcplus4;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Fetch addresses are always word aligned; low two bits are forced to zero.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/ifetch_prefetch_unit_fetch_fifo.sv
// DEPTH-entry FIFO of fetch entries feeding the IF/ID register.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   flush           : clear all entries (wins over push/pop)
//   push, push_data : enqueue one entry
//   pop             : dequeue the head entry (ignored when empty)
//   head            : current head entry, combinational from storage
//   count           : number of valid entries (0..DEPTH)
//   empty, full     : status flags derived from count
module ifetch_prefetch_unit_fetch_fifo
  import ifetch_prefetch_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t   mem [DEPTH];
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;
  logic           do_push;
  logic           do_pop;

  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && !empty;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign head  = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

  // Storage carries data only; validity is tracked by the pointers above.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ifetch_prefetch_unit.sv
// Instruction-fetch front end ahead of the IF/ID register. Issues sequential
// word fetches to a variable-latency memory (one outstanding request), queues
// the returned instructions and presents {pcplus4, instruction} downstream.
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   stall                     : ID hazard hold, blocks dequeue
//   redirect, redirect_pc     : taken branch/jump; flush queue, refetch at target
//   imem_req, imem_addr       : fetch request toward instruction memory
//   imem_ack, imem_rdata      : memory response (data valid with ack)
//   out_valid                 : queue head valid
//   out_instruction           : head instruction, NOP when empty
//   out_pcplus4               : head fetch address + 4, zero when empty
module ifetch_prefetch_unit
  import ifetch_prefetch_unit_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  output logic [31:0] out_instruction,
  output logic [31:0] out_pcplus4
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e  state, state_next;
  logic [31:0]   fetch_pc, fetch_pc_next;
  logic [31:0]   req_addr, req_addr_next;
  logic [31:0]   req_addr_plus4;
  logic [31:0]   target;
  logic          push, pop;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;
  logic [CW-1:0] count, count_next;
  logic          empty, full;

  assign target         = word_align(redirect_pc);
  assign req_addr_plus4 = req_addr + 32'd4;
  assign imem_addr      = req_addr;

  // Redirect outranks both stall and dequeue.
  assign pop  = !empty && !stall && !redirect;
  assign push = (state == WAIT) && imem_ack && !redirect;
  assign push_entry = '{pcplus4: req_addr_plus4, instr: imem_rdata};

  // Occupancy after this edge; decides whether another request may be issued.
  always_comb begin
    count_next = count;
    if (redirect)            count_next = '0;
    else if (push && !pop)   count_next = count + CW'(1);
    else if (pop && !push)   count_next = count - CW'(1);
  end

  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    req_addr_next = req_addr;
    imem_req      = 1'b0;
    unique case (state)
      IDLE: begin
        if (redirect) begin
          fetch_pc_next = target;
        end else if (count_next < CW'(DEPTH)) begin
          state_next    = WAIT;
          req_addr_next = fetch_pc;
        end
      end
      WAIT: begin
        imem_req = 1'b1;
        if (redirect) begin
          fetch_pc_next = target;
          // An unacked request must still complete before the target is fetched.
          if (imem_ack) req_addr_next = target;
          else          state_next    = DISCARD;
        end else if (imem_ack) begin
          fetch_pc_next = req_addr_plus4;
          if (count_next < CW'(DEPTH)) req_addr_next = req_addr_plus4;
          else                         state_next    = IDLE;
        end
      end
      DISCARD: begin
        imem_req = 1'b1;
        if (redirect) fetch_pc_next = target;
        if (imem_ack) begin
          state_next    = WAIT;
          req_addr_next = redirect ? target : fetch_pc;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
      req_addr <= req_addr_next;
    end
  end

  ifetch_prefetch_unit_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .empty     (empty),
    .full      (full)
  );

  assign out_valid       = !empty;
  assign out_instruction = empty ? NOP_INSTR : head.instr;
  assign out_pcplus4     = empty ? 32'h0 : head.pcplus4;

  // Requests are only issued while there is room, so a push can never hit a full queue.
  assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: tb/tb_ifetch_prefetch_unit.sv
module tb_ifetch_prefetch_unit;
  import ifetch_prefetch_unit_pkg::*;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        out_valid;
  logic [31:0] out_instruction;
  logic [31:0] out_pcplus4;

  always #5 clk = ~clk;

  ifetch_prefetch_unit #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .out_valid       (out_valid),
    .out_instruction (out_instruction),
    .out_pcplus4     (out_pcplus4)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: expected queue contents, next useful fetch address,
  // whether the outstanding request is stale, and whether a request is expected.
  fetch_entry_t mq[$];
  logic [31:0]  m_next_pc;
  bit           m_stale;
  bit           m_req;
  int           lat;
  int           wcnt;
  bit           rand_lat;
  bit           prev_hold;
  logic [31:0]  prev_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a ^ 32'h5EED_0000) * 32'h9E37_79B1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_next_pc = RESET_PC;
    m_stale   = 1'b0;
    m_req     = 1'b0;
    wcnt      = 0;
    prev_hold = 1'b0;
    prev_addr = 32'h0;
  endtask

  task automatic check_outputs();
    chk("imem_req", 32'(imem_req), 32'(m_req));
    chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    chk("out_pcplus4", out_pcplus4, (mq.size() != 0) ? mq[0].pcplus4 : 32'h0);
    chk("out_instruction", out_instruction, (mq.size() != 0) ? mq[0].instr : NOP_INSTR);
    if (prev_hold && imem_req) chk("imem_addr_stable", imem_addr, prev_addr);
  endtask

  // One clock: check at the falling edge, drive, then advance the model at the rising edge.
  task automatic step(input bit st, input bit rd, input logic [31:0] rpc);
    logic        s_req;
    logic [31:0] s_addr;
    logic [31:0] d;
    bit          ack;
    check_outputs();
    s_req  = imem_req;
    s_addr = imem_addr;
    ack    = s_req && (wcnt >= lat);
    d      = ack ? mem_word(s_addr) : $urandom;
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    imem_ack    = ack;
    imem_rdata  = d;
    @(posedge clk);
    if (rd) begin
      mq.delete();
      m_next_pc = rpc & 32'hFFFF_FFFC;
      m_stale   = s_req && !ack;
      m_req     = s_req;
    end else begin
      if (mq.size() != 0 && !st) void'(mq.pop_front());
      if (ack) begin
        if (m_stale) begin
          m_stale = 1'b0;
          m_req   = 1'b1;
        end else begin
          chk("fetch_addr", s_addr, m_next_pc);
          mq.push_back('{pcplus4: m_next_pc + 32'd4, instr: d});
          m_next_pc = m_next_pc + 32'd4;
          m_req     = (mq.size() < DEPTH);
        end
      end else if (!s_req) begin
        m_req = (mq.size() < DEPTH);
      end else begin
        m_req = 1'b1;
      end
    end
    if (ack) begin
      wcnt = 0;
      if (rand_lat) lat = $urandom_range(0, 3);
    end else if (s_req) begin
      wcnt++;
    end
    prev_hold = s_req && !ack;
    prev_addr = s_addr;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_imem_addr", imem_addr, RESET_PC);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    lat = 0;
    rand_lat = 1'b0;
    model_reset();

    // Reset values and zero-wait streaming.
    do_reset();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_pcplus4", out_pcplus4, 32'h0);
    chk("rst_out_instruction", out_instruction, 32'h0);
    repeat (16) step(1'b0, 1'b0, 32'h0);

    // Stall held from reset: queue fills, requests stop, head stays on the first entry.
    do_reset();
    repeat (8) step(1'b1, 1'b0, 32'h0);
    chk("full_no_req", 32'(imem_req), 32'd0);
    chk("full_head", out_pcplus4, RESET_PC + 32'd4);
    repeat (8) step(1'b0, 1'b0, 32'h0);

    // Three-cycle memory, redirect in the first WAIT cycle.
    do_reset();
    lat = 3;
    step(1'b0, 1'b0, 32'h0);
    chk("first_wait_req", 32'(imem_req), 32'd1);
    step(1'b0, 1'b1, 32'h100);
    for (int i = 0; i < 20 && !out_valid; i++) step(1'b0, 1'b0, 32'h0);
    chk("redir_first_pcplus4", out_pcplus4, 32'h104);
    repeat (4) step(1'b0, 1'b0, 32'h0);

    // Redirect in the same cycle as an ack.
    do_reset();
    lat = 0;
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h200);
    chk("redir_ack_valid", 32'(out_valid), 32'd0);
    chk("redir_ack_addr", imem_addr, 32'h200);
    repeat (6) step(1'b0, 1'b0, 32'h0);

    // Redirect and stall together with three entries queued.
    do_reset();
    for (int i = 0; i < 10 && mq.size() < 3; i++) step(1'b1, 1'b0, 32'h0);
    chk("three_queued_valid", 32'(out_valid), 32'd1);
    step(1'b1, 1'b1, 32'h300);
    chk("redir_stall_valid", 32'(out_valid), 32'd0);
    repeat (6) step(1'b0, 1'b0, 32'h0);

    // Asynchronous reset in the middle of a WAIT with entries queued.
    do_reset();
    repeat (3) step(1'b1, 1'b0, 32'h0);
    lat = 3;
    step(1'b1, 1'b0, 32'h0);
    chk("pre_arst_req", 32'(imem_req), 32'd1);
    chk("pre_arst_valid", 32'(out_valid), 32'd1);
    stall = 1'b0; redirect = 1'b0; imem_ack = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_req", 32'(imem_req), 32'd0);
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_pcplus4", out_pcplus4, 32'h0);
    chk("arst_addr", imem_addr, RESET_PC);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (10) step(1'b0, 1'b0, 32'h0);

    // Address wrap at the top of the address space (unaligned target bits ignored).
    do_reset();
    lat = 0;
    step(1'b0, 1'b1, 32'hFFFF_FFFE);
    for (int i = 0; i < 10 && !out_valid; i++) step(1'b0, 1'b0, 32'h0);
    chk("wrap_pcplus4", out_pcplus4, 32'h0);
    repeat (4) step(1'b0, 1'b0, 32'h0);

    // Randomized traffic: latency, stall and redirects.
    do_reset();
    rand_lat = 1'b1;
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
